quantizer_wb_block: RTL

- Wishbone-slave JPEG quantizer that processes a full 8x8 block per start command, instead of one coefficient per trigger.
- Software loads BLOCK_N DCT coefficients and a per-index reciprocal quantization table, then writes START.
- The block runs a 2-stage pipeline over all entries, applying truncate or round-half-away-from-zero with saturation, and raises DONE/IRQ.
- Sits between the DCT stage and the zig-zag/entropy stage on the system Wishbone bus.

---
 rtl/quantizer_wb_block.sv | 264 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/quantizer_wb_block.sv
// Wishbone-slave JPEG quantizer: multiplies a block of coefficients by per-index reciprocals, truncates or rounds, saturates.
// Latency: one wait state per bus access; START-to-DONE is BLOCK_N+3 cycles from the START ACK cycle.
// Backpressure: none; every access is ACKed after one wait state, and writes that cannot be applied while busy are dropped.
module quantizer_wb_block #(
    parameter int COEF_W  = 16,
    parameter int RECIP_W = 16,
    parameter int BLOCK_N = 64,
    parameter int ADDR_W  = 12
) (
    input  logic              CLK_I,
    input  logic              RST_N_I,
    input  logic [ADDR_W-1:0] ADR_I,
    input  logic [31:0]       DAT_I,
    output logic [31:0]       DAT_O,
    input  logic              WE_I,
    input  logic              STB_I,
    input  logic              CYC_I,
    input  logic [3:0]        SEL_I,
    output logic              ACK_O,
    output logic              IRQ_O,
    output logic              busy_monitor,
    output logic              done_monitor
);

    localparam int IDX_W  = $clog2(BLOCK_N);
    localparam int PROD_W = COEF_W + RECIP_W;

    localparam logic [ADDR_W-9:0] PG_REG   = (ADDR_W-8)'(0);
    localparam logic [ADDR_W-9:0] PG_COEF  = (ADDR_W-8)'(1);
    localparam logic [ADDR_W-9:0] PG_RECIP = (ADDR_W-8)'(2);
    localparam logic [ADDR_W-9:0] PG_RES   = (ADDR_W-8)'(3);
    localparam logic [6:0]        BLK_LIM  = 7'(BLOCK_N);
    localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(BLOCK_N - 1);

    localparam logic [PROD_W:0] RND_HALF = {{(PROD_W-RECIP_W+1){1'b0}}, 1'b1, {(RECIP_W-1){1'b0}}};
    localparam logic [COEF_W:0] SAT_POS  = {2'b00, {(COEF_W-1){1'b1}}};
    localparam logic [COEF_W:0] SAT_NEG  = {2'b01, {(COEF_W-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    function automatic logic [31:0] f_merge(input logic [31:0] i_old, input logic [31:0] i_new,
                                            input logic [3:0] i_sel);
        logic [31:0] v;
        v = i_old;
        for (int b = 0; b < 4; b++) begin
            if (i_sel[b]) v[8*b +: 8] = i_new[8*b +: 8];
        end
        return v;
    endfunction

    // Storage and control state
    logic [COEF_W-1:0]  r_coef   [BLOCK_N];
    logic [RECIP_W-1:0] r_recip  [BLOCK_N];
    logic [COEF_W-1:0]  r_result [BLOCK_N];

    state_t            r_state;
    state_t            w_state_nxt;
    logic              r_ack;
    logic [31:0]       r_dat;
    logic              r_ctrl_round;
    logic              r_ctrl_irq;
    logic              r_round_act;
    logic              r_irq_act;
    logic              r_start_pend;
    logic              r_done;
    logic              r_err;
    logic              r_drain;
    logic [IDX_W-1:0]  r_index;

    logic              r_s1_vld;
    logic              r_s1_neg;
    logic [IDX_W-1:0]  r_s1_idx;
    logic [PROD_W-1:0] r_s1_prod;

    // Bus decode
    logic [ADDR_W-9:0] w_page;
    logic [5:0]        w_word;
    logic [IDX_W-1:0]  w_k;
    logic              w_in_blk;
    logic              w_req, w_wr, w_rd, w_busy;
    logic              w_hit_ctrl, w_hit_status, w_hit_index;
    logic              w_hit_coef, w_hit_recip, w_hit_res;
    logic              w_start_wr, w_w1c_done, w_w1c_err;
    logic              w_s1_fire, w_set_done, w_run_go;
    logic [31:0]       w_coef_mrg, w_recip_mrg, w_rdat;

    assign w_page       = ADR_I[ADDR_W-1:8];
    assign w_word       = ADR_I[7:2];
    assign w_k          = w_word[IDX_W-1:0];
    assign w_in_blk     = ({1'b0, w_word} < BLK_LIM);
    assign w_req        = STB_I & CYC_I & ~r_ack;
    assign w_wr         = w_req & WE_I;
    assign w_rd         = w_req & ~WE_I;
    assign w_busy       = (r_state != S_IDLE);

    assign w_hit_ctrl   = (w_page == PG_REG) && (w_word == 6'd0);
    assign w_hit_status = (w_page == PG_REG) && (w_word == 6'd1);
    assign w_hit_index  = (w_page == PG_REG) && (w_word == 6'd2);
    assign w_hit_coef   = (w_page == PG_COEF) && w_in_blk;
    assign w_hit_recip  = (w_page == PG_RECIP) && w_in_blk;
    assign w_hit_res    = (w_page == PG_RES) && w_in_blk;

    assign w_start_wr   = w_wr & w_hit_ctrl & SEL_I[0] & DAT_I[0];
    assign w_w1c_done   = w_wr & w_hit_status & SEL_I[0] & DAT_I[1];
    assign w_w1c_err    = w_wr & w_hit_status & SEL_I[0] & DAT_I[2];

    assign w_coef_mrg   = f_merge({{(32-COEF_W){1'b0}}, r_coef[w_k]}, DAT_I, SEL_I);
    assign w_recip_mrg  = f_merge({{(32-RECIP_W){1'b0}}, r_recip[w_k]}, DAT_I, SEL_I);

    // Stage 1 operand fetch: magnitude of the coefficient times its reciprocal
    logic [COEF_W-1:0]  w_c;
    logic [RECIP_W-1:0] w_r;
    logic [COEF_W-1:0]  w_mag;
    logic [PROD_W-1:0]  w_prod;
    assign w_c    = r_coef[r_index];
    assign w_r    = r_recip[r_index];
    assign w_mag  = w_c[COEF_W-1] ? (~w_c + 1'b1) : w_c;
    assign w_prod = {{RECIP_W{1'b0}}, w_mag} * {{COEF_W{1'b0}}, w_r};

    // Stage 2 rounding, scaling and saturation
    logic [PROD_W:0]   w_sum;
    logic [COEF_W:0]   w_q;
    logic [COEF_W-1:0] w_res;
    assign w_sum = {1'b0, r_s1_prod} + (r_round_act ? RND_HALF : '0);
    assign w_q   = w_sum[PROD_W:RECIP_W];

    // Apply the sign after scaling so a zero magnitude always yields +0
    always_comb begin
        w_res = '0;
        if (r_s1_neg) begin
            if (w_q > SAT_NEG) w_res = {1'b1, {(COEF_W-1){1'b0}}};
            else               w_res = ~w_q[COEF_W-1:0] + 1'b1;
        end else begin
            if (w_q > SAT_POS) w_res = {1'b0, {(COEF_W-1){1'b1}}};
            else               w_res = w_q[COEF_W-1:0];
        end
    end

    // FSM next state: RUN walks the index once, DRAIN gives stage 2 two cycles to retire
    always_comb begin
        w_state_nxt = r_state;
        w_s1_fire   = 1'b0;
        w_set_done  = 1'b0;
        w_run_go    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (r_start_pend) begin
                    w_state_nxt = S_RUN;
                    w_run_go    = 1'b1;
                end
            end
            S_RUN: begin
                w_s1_fire = 1'b1;
                if (r_index == IDX_LAST) w_state_nxt = S_DRAIN;
            end
            S_DRAIN: begin
                if (r_drain) begin
                    w_state_nxt = S_IDLE;
                    w_set_done  = 1'b1;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Read data mux for the access being acknowledged
    always_comb begin
        w_rdat = '0;
        if (w_hit_ctrl)        w_rdat = {29'd0, r_ctrl_irq, r_ctrl_round, 1'b0};
        else if (w_hit_status) w_rdat = {29'd0, r_err, r_done, w_busy};
        else if (w_hit_index)  w_rdat = {{(32-IDX_W){1'b0}}, r_index};
        else if (w_hit_coef)   w_rdat = {{(32-COEF_W){1'b0}}, r_coef[w_k]};
        else if (w_hit_recip)  w_rdat = {{(32-RECIP_W){1'b0}}, r_recip[w_k]};
        else if (w_hit_res)    w_rdat = {{(32-COEF_W){r_result[w_k][COEF_W-1]}}, r_result[w_k]};
    end

    // Bus handshake, control/status registers, FSM and index
    always_ff @(posedge CLK_I or negedge RST_N_I) begin
        if (!RST_N_I) begin
            r_ack        <= 1'b0;
            r_dat        <= '0;
            r_ctrl_round <= 1'b0;
            r_ctrl_irq   <= 1'b0;
            r_round_act  <= 1'b0;
            r_irq_act    <= 1'b0;
            r_start_pend <= 1'b0;
            r_done       <= 1'b0;
            r_err        <= 1'b0;
            r_drain      <= 1'b0;
            r_index      <= '0;
            r_state      <= S_IDLE;
        end else begin
            r_ack        <= w_req;
            r_dat        <= w_rd ? w_rdat : '0;
            r_state      <= w_state_nxt;
            r_start_pend <= w_start_wr & ~w_busy;
            r_drain      <= (r_state == S_DRAIN) ? ~r_drain : 1'b0;
            if (w_wr && w_hit_ctrl && SEL_I[0]) begin
                r_ctrl_round <= DAT_I[1];
                r_ctrl_irq   <= DAT_I[2];
            end
            // Mode bits only reach the datapath while idle, so a run keeps the mode it started with
            if (!w_busy) begin
                r_round_act <= r_ctrl_round;
                r_irq_act   <= r_ctrl_irq;
            end
            if (w_set_done)      r_done <= 1'b1;
            else if (w_run_go)   r_done <= 1'b0;
            else if (w_w1c_done) r_done <= 1'b0;
            if (w_start_wr && w_busy) r_err <= 1'b1;
            else if (w_w1c_err)       r_err <= 1'b0;
            if (w_run_go)                               r_index <= '0;
            else if (w_s1_fire && r_index != IDX_LAST)  r_index <= r_index + 1'b1;
        end
    end

    // Reciprocal table, reset to the all-ones reciprocal so an unloaded entry passes values nearly unchanged
    always_ff @(posedge CLK_I or negedge RST_N_I) begin
        if (!RST_N_I) begin
            for (int i = 0; i < BLOCK_N; i++) r_recip[i] <= '1;
        end else if (w_wr && w_hit_recip && !w_busy) begin
            r_recip[w_k] <= w_recip_mrg[RECIP_W-1:0];
        end
    end

    // Stage 1 pipeline register
    always_ff @(posedge CLK_I or negedge RST_N_I) begin
        if (!RST_N_I) begin
            r_s1_vld  <= 1'b0;
            r_s1_neg  <= 1'b0;
            r_s1_idx  <= '0;
            r_s1_prod <= '0;
        end else begin
            r_s1_vld  <= w_s1_fire;
            r_s1_neg  <= w_c[COEF_W-1];
            r_s1_idx  <= r_index;
            r_s1_prod <= w_prod;
        end
    end

    // Coefficient buffer, no reset
    always_ff @(posedge CLK_I) begin
        if (w_wr && w_hit_coef && !w_busy) r_coef[w_k] <= w_coef_mrg[COEF_W-1:0];
    end

    // Result buffer written by stage 2, no reset
    always_ff @(posedge CLK_I) begin
        if (r_s1_vld) r_result[r_s1_idx] <= w_res;
    end

    logic w_unused;
    assign w_unused = &{1'b0, ADR_I[1:0], w_coef_mrg[31:COEF_W], w_recip_mrg[31:RECIP_W], w_sum[RECIP_W-1:0]};

    assign ACK_O        = r_ack;
    assign DAT_O        = r_dat;
    assign IRQ_O        = r_done & r_irq_act;
    assign busy_monitor = w_busy;
    assign done_monitor = r_done;

endmodule
